// File: rtl/mdio_wb_sequencer.sv
// MDIO register access sequencer driving a MAC register port over Wishbone.
// Optional MIISTATUS poll limit enabled by defining MDIO_SEQ_TIMEOUT_EN.
module mdio_wb_sequencer #(
    parameter logic [4:0]  PHY_ADDR   = 5'd7,
    parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        wb_stb,
    output logic        wb_cyc,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        busy
);

    localparam logic [7:0] A_ADDR = 8'h18;
    localparam logic [7:0] A_TXD  = 8'h1C;
    localparam logic [7:0] A_CMD  = 8'h20;
    localparam logic [7:0] A_STAT = 8'h24;
    localparam logic [7:0] A_RXD  = 8'h28;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_TXD, S_CMD, S_STAT, S_CHECK, S_RXD, S_RSP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_done;
    logic        r_write;
    logic [4:0]  r_reg;
    logic [15:0] r_wdata;
    logic [15:0] r_cap;
    logic [15:0] r_rdata;
    logic        w_bus;
    logic        w_take;
    logic        w_accept;
    logic        w_timeout;

    assign w_bus = (r_state == S_ADDR) || (r_state == S_TXD) ||
                   (r_state == S_CMD)  || (r_state == S_STAT) ||
                   (r_state == S_RXD);
    // An access completes on the first ack seen while strobing.
    assign w_take   = w_bus && !r_done && wb_ack;
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef MDIO_SEQ_TIMEOUT_EN
    logic [15:0] r_poll;
    logic        r_timeout;

    assign w_timeout = (r_state == S_CHECK) && r_cap[1] &&
                       (r_poll >= POLL_LIMIT);

    // Count MIISTATUS reads; flag a give-up for the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_poll    <= 16'd0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_poll    <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_take && (r_state == S_STAT))
                r_poll <= r_poll + 16'd1;
            if (w_timeout)
                r_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = (r_state == S_RSP) && r_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: each bus state advances the cycle after its ack.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (req_valid) w_next = S_ADDR;
            S_ADDR:  if (r_done) w_next = r_write ? S_TXD : S_CMD;
            S_TXD:   if (r_done) w_next = S_CMD;
            S_CMD:   if (r_done) w_next = S_STAT;
            S_STAT:  if (r_done) w_next = S_CHECK;
            S_CHECK: begin
                if (!r_cap[1])
                    w_next = r_write ? S_RSP : S_RXD;
                else if (w_timeout)
                    w_next = S_RSP;
                else
                    w_next = S_STAT;
            end
            S_RXD:   if (r_done) w_next = S_RSP;
            S_RSP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: bus fields decoded from state and latched request.
    always_comb begin
        wb_adr   = 8'h00;
        wb_dat_o = 32'd0;
        wb_we    = 1'b0;
        unique case (r_state)
            S_ADDR: begin
                wb_adr   = A_ADDR;
                wb_dat_o = {19'd0, r_reg, 3'd0, PHY_ADDR};
                wb_we    = 1'b1;
            end
            S_TXD: begin
                wb_adr   = A_TXD;
                wb_dat_o = {16'd0, r_wdata};
                wb_we    = 1'b1;
            end
            S_CMD: begin
                wb_adr   = A_CMD;
                wb_dat_o = r_write ? 32'd4 : 32'd2;
                wb_we    = 1'b1;
            end
            S_STAT:  wb_adr = A_STAT;
            S_RXD:   wb_adr = A_RXD;
            default: ;
        endcase
        wb_stb    = w_bus && !r_done;
        wb_cyc    = w_bus && !r_done;
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        rsp_valid = (r_state == S_RSP);
    end

    // Ack tracking, request latch and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_reg   <= 5'd0;
            r_wdata <= 16'd0;
            r_cap   <= 16'd0;
            r_rdata <= 16'd0;
        end else begin
            r_done <= w_take;
            if (w_accept) begin
                r_write <= req_write;
                r_reg   <= req_reg;
                r_wdata <= req_wdata;
            end
            if (w_take && ((r_state == S_STAT) || (r_state == S_RXD)))
                r_cap <= wb_dat_i[15:0];
            if ((r_state == S_RXD) && r_done)
                r_rdata <= r_cap;
        end
    end

    assign rsp_rdata = r_rdata;

endmodule
